uart_tx_port: RTL

Memory-mapped UART transmitter on the CPU data-memory port, downstream of the CPU's `ram_addr`/`ram_dout`/`ram_we` outputs. It decodes a two-word window at the top of data space and buffers written bytes in a small FIFO. It serialises the bytes as 8N1 frames on `o_tx`. Its read data is muxed by the top level into the CPU's `ram_din` whenever `o_sel` is high.

---
 rtl/uart_tx_port.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS register pair at the top of data
// space feeds a small byte FIFO that drains through a baud-timed shift FSM onto o_tx.
module uart_tx_port #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(12'hFF0),
  parameter int unsigned            CLK_DIV    = 434,
  parameter int unsigned            FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sel,
  output logic                  o_tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overrun_q, overrun_d;
  logic               tx_q, tx_d;
  logic [7:0]         mem [FIFO_DEPTH];

  logic bit_end, full, empty, busy, pop;
  logic push_req, push_ok, clr_req;
  logic [15:0] status;
  logic unused_data;

  assign o_sel    = (i_addr[ADDR_WIDTH-1:1] == BASE_ADDR[ADDR_WIDTH-1:1]);
  assign push_req = i_we & o_sel & ~i_addr[0];
  assign clr_req  = i_we & o_sel & i_addr[0] & i_data[3];
  assign bit_end  = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted.
  assign push_ok  = push_req & (~full | pop);
  assign unused_data = ^i_data[DATA_WIDTH-1:8];

  assign status = {8'(count_q), 4'b0, overrun_q, busy, empty, full};
  assign o_data = (o_sel && i_addr[0]) ? DATA_WIDTH'(status) : '0;
  assign o_tx   = tx_q;

  // FIFO storage; flushing is done through the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    tx_d      = 1'b1;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the upcoming state so it aligns with the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

    // A dropped write wins over a simultaneous clear.
    if (push_req && full && !pop) overrun_d = 1'b1;
    else if (clr_req)             overrun_d = 1'b0;
  end

endmodule
